// File: rtl/escalonador_round_robin_if.sv
// -----------------------------------------------------------------------------
// escalonador_round_robin_if
//   Bundle between the round-robin process scheduler and the CPU/OS side.
//
//   CPU -> scheduler (master drives):
//     enable        scheduler active; low freezes the scheduler
//     pc            PC of the running process, captured on preemption
//     instr_io      running process issued IO (block it)
//     fim_processo  running process terminated
//     io_done       IO complete for io_done_pid
//     cria_valid    create process cria_pid starting at cria_pc
//   scheduler -> CPU (slave drives):
//     troca_contexto  one-cycle pulse: load pc_proximo into the CPU PC
//     pc_proximo      PC of the dispatched process
//     pc_salvo        PC saved for the outgoing process (0 on termination)
//     processo_atual  running pid
//     quantum_rest    remaining slice cycles
//     ocioso          no ready process exists
//     erro_cria       one-cycle pulse: creation refused
// -----------------------------------------------------------------------------
interface escalonador_round_robin_if #(
    parameter int PID_W = 3,
    parameter int PC_W  = 32,
    parameter int Q_W   = 8
);
    logic             enable;
    logic [PC_W-1:0]  pc;
    logic             instr_io;
    logic             fim_processo;
    logic             io_done;
    logic [PID_W-1:0] io_done_pid;
    logic             cria_valid;
    logic [PID_W-1:0] cria_pid;
    logic [PC_W-1:0]  cria_pc;

    logic             troca_contexto;
    logic [PC_W-1:0]  pc_proximo;
    logic [PC_W-1:0]  pc_salvo;
    logic [PID_W-1:0] processo_atual;
    logic [Q_W-1:0]   quantum_rest;
    logic             ocioso;
    logic             erro_cria;

    // Scheduler side
    modport slave (
        input  enable, pc, instr_io, fim_processo, io_done, io_done_pid,
               cria_valid, cria_pid, cria_pc,
        output troca_contexto, pc_proximo, pc_salvo, processo_atual,
               quantum_rest, ocioso, erro_cria
    );

    // CPU / OS side
    modport master (
        output enable, pc, instr_io, fim_processo, io_done, io_done_pid,
               cria_valid, cria_pid, cria_pc,
        input  troca_contexto, pc_proximo, pc_salvo, processo_atual,
               quantum_rest, ocioso, erro_cria
    );
endinterface

// File: rtl/escalonador_round_robin.sv
// -----------------------------------------------------------------------------
// escalonador_round_robin
//   Round-robin process scheduler with a fixed table of NUM_PROC slots. Each
//   slot holds a status (LIVRE/PRONTO/EXECUTANDO/BLOQUEADO) and a saved PC.
//   A three-state FSM (OCIOSO/SELECIONA/EXECUTA) picks the next ready slot
//   after the current pid, runs it for QUANTUM cycles and preempts it on
//   termination, IO or slice expiry. All outputs are registered.
//
//   Ports:
//     clock_i   single clock, all state changes on its rising edge
//     reset_i   synchronous active-high reset
//     sched_io  escalonador_round_robin_if.slave (CPU handshake, see _if file)
// -----------------------------------------------------------------------------
module escalonador_round_robin #(
    parameter int NUM_PROC = 8,
    parameter int PID_W    = 3,
    parameter int PC_W     = 32,
    parameter int QUANTUM  = 16,
    parameter int Q_W      = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    escalonador_round_robin_if.slave sched_io
);

    typedef enum logic [1:0] {
        LIVRE      = 2'd0,
        PRONTO     = 2'd1,
        EXECUTANDO = 2'd2,
        BLOQUEADO  = 2'd3
    } slot_st_e;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        SELECIONA = 2'd1,
        EXECUTA   = 2'd2
    } fsm_e;

    localparam logic [PID_W-1:0] LAST_PID = PID_W'(NUM_PROC - 1);
    localparam logic [PID_W:0]   NPROC    = (PID_W + 1)'(NUM_PROC);
    localparam logic [Q_W-1:0]   QUANT    = Q_W'(QUANTUM);

    fsm_e             state_q, state_d;
    slot_st_e         st_q  [NUM_PROC];
    slot_st_e         st_d  [NUM_PROC];
    logic [PC_W-1:0]  spc_q [NUM_PROC];
    logic [PC_W-1:0]  spc_d [NUM_PROC];
    logic [PID_W-1:0] atual_q, atual_d;
    logic [PC_W-1:0]  pcprox_q, pcprox_d;
    logic [PC_W-1:0]  pcsalvo_q, pcsalvo_d;
    logic [Q_W-1:0]   quant_q, quant_d;
    logic             troca_q, troca_d;
    logic             erro_q, erro_d;
    logic             ocioso_q, ocioso_d;

    logic             en;
    logic             sel_found;
    logic [PID_W-1:0] sel_pid;
    logic [PID_W-1:0] scan_idx;
    logic             ev_fim, ev_io, ev_exp;
    logic             iod_ok, cria_ok;

    assign en = sched_io.enable;

    // Ring scan starting one past the running pid and ending on the running
    // pid itself, so a lone expired process is found again. Because every
    // slot is visited, sel_found doubles as "some slot is PRONTO".
    always_comb begin
        sel_found = 1'b0;
        sel_pid   = '0;
        scan_idx  = atual_q;
        for (int k = 0; k < NUM_PROC; k++) begin
            scan_idx = (scan_idx == LAST_PID) ? '0 : scan_idx + 1'b1;
            if (!sel_found && st_q[scan_idx] == PRONTO) begin
                sel_found = 1'b1;
                sel_pid   = scan_idx;
            end
        end
    end

    // Only one preemption event is taken, highest priority first.
    always_comb begin
        ev_fim = en && (state_q == EXECUTA) && sched_io.fim_processo;
        ev_io  = en && (state_q == EXECUTA) && !sched_io.fim_processo
                 && sched_io.instr_io;
        ev_exp = en && (state_q == EXECUTA) && !sched_io.fim_processo
                 && !sched_io.instr_io && (quant_q == Q_W'(1));
    end

    assign iod_ok  = ({1'b0, sched_io.io_done_pid} < NPROC);
    assign cria_ok = ({1'b0, sched_io.cria_pid} < NPROC);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= OCIOSO;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                OCIOSO:    if (sel_found) state_d = SELECIONA;
                SELECIONA: state_d = sel_found ? EXECUTA : OCIOSO;
                EXECUTA:   if (ev_fim || ev_io || ev_exp) state_d = SELECIONA;
                default:   state_d = OCIOSO;
            endcase
        end
    end

    // ---------------- FSM: outputs and table next-state ----------------
    // Create/io_done decisions look at st_q, so writes landing on the
    // SELECIONA edge never influence that edge's selection.
    always_comb begin
        st_d      = st_q;
        spc_d     = spc_q;
        atual_d   = atual_q;
        pcprox_d  = pcprox_q;
        pcsalvo_d = pcsalvo_q;
        quant_d   = quant_q;
        troca_d   = 1'b0;
        erro_d    = 1'b0;
        ocioso_d  = (state_d == OCIOSO);

        if (en) begin
            case (state_q)
                SELECIONA: begin
                    if (sel_found) begin
                        st_d[sel_pid] = EXECUTANDO;
                        atual_d       = sel_pid;
                        pcprox_d      = spc_q[sel_pid];
                        quant_d       = QUANT;
                        troca_d       = 1'b1;
                    end
                end
                EXECUTA: begin
                    quant_d = quant_q - Q_W'(1);
                    if (ev_fim) begin
                        st_d[atual_q] = LIVRE;
                        pcsalvo_d     = '0;
                    end else if (ev_io) begin
                        st_d[atual_q]  = BLOQUEADO;
                        spc_d[atual_q] = sched_io.pc;
                        pcsalvo_d      = sched_io.pc;
                    end else if (ev_exp) begin
                        st_d[atual_q]  = PRONTO;
                        spc_d[atual_q] = sched_io.pc;
                        pcsalvo_d      = sched_io.pc;
                    end
                end
                default: ;
            endcase

            // An IO completion racing the block of the same pid wins.
            if (sched_io.io_done && iod_ok) begin
                if (st_q[sched_io.io_done_pid] == BLOQUEADO ||
                    (ev_io && sched_io.io_done_pid == atual_q))
                    st_d[sched_io.io_done_pid] = PRONTO;
            end

            if (sched_io.cria_valid) begin
                if (cria_ok && st_q[sched_io.cria_pid] == LIVRE) begin
                    st_d[sched_io.cria_pid]  = PRONTO;
                    spc_d[sched_io.cria_pid] = sched_io.cria_pc;
                end else begin
                    erro_d = 1'b1;
                end
            end
        end
    end

    // ---------------- table and output registers ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                st_q[i]  <= LIVRE;
                spc_q[i] <= '0;
            end
            atual_q   <= '0;
            pcprox_q  <= '0;
            pcsalvo_q <= '0;
            quant_q   <= '0;
            troca_q   <= 1'b0;
            erro_q    <= 1'b0;
            ocioso_q  <= 1'b1;
        end else begin
            st_q      <= st_d;
            spc_q     <= spc_d;
            atual_q   <= atual_d;
            pcprox_q  <= pcprox_d;
            pcsalvo_q <= pcsalvo_d;
            quant_q   <= quant_d;
            troca_q   <= troca_d;
            erro_q    <= erro_d;
            ocioso_q  <= ocioso_d;
        end
    end

    assign sched_io.troca_contexto = troca_q;
    assign sched_io.pc_proximo     = pcprox_q;
    assign sched_io.pc_salvo       = pcsalvo_q;
    assign sched_io.processo_atual = atual_q;
    assign sched_io.quantum_rest   = quant_q;
    assign sched_io.ocioso         = ocioso_q;
    assign sched_io.erro_cria      = erro_q;

endmodule

// File: tb/tb_escalonador_round_robin.sv
// -----------------------------------------------------------------------------
// tb_escalonador_round_robin
//   Directed scenarios plus randomized traffic for escalonador_round_robin,
//   checked every cycle against a process-table reference model.
// -----------------------------------------------------------------------------
module tb_escalonador_round_robin;
    localparam int NP = 8;
    localparam int PW = 3;
    localparam int CW = 32;
    localparam int QN = 4;
    localparam int QW = 8;

    localparam int S_LIVRE = 0, S_PRONTO = 1, S_EXEC = 2, S_BLOQ = 3;
    localparam int F_IDLE = 0, F_SEL = 1, F_RUN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    escalonador_round_robin_if #(.PID_W(PW), .PC_W(CW), .Q_W(QW)) bus ();

    escalonador_round_robin #(
        .NUM_PROC(NP), .PID_W(PW), .PC_W(CW), .QUANTUM(QN), .Q_W(QW)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .sched_io(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_st [NP];
    logic [31:0] m_pc [NP];
    int          m_fsm, m_cur, m_q;
    logic [31:0] m_prox, m_salvo;
    bit          m_troca, m_erro;

    task automatic model_step();
        int old [NP];
        int win, q0, blocked, p;
        if (rst) begin
            foreach (m_st[i]) begin m_st[i] = S_LIVRE; m_pc[i] = 0; end
            m_fsm = F_IDLE; m_cur = 0; m_q = 0; m_prox = 0; m_salvo = 0;
            m_troca = 0; m_erro = 0;
            return;
        end
        m_troca = 0;
        m_erro  = 0;
        if (!bus.enable) return;
        old = m_st;
        blocked = -1;
        case (m_fsm)
            F_IDLE: begin
                foreach (old[i]) if (old[i] == S_PRONTO) m_fsm = F_SEL;
            end
            F_SEL: begin
                win = -1;
                for (int k = 1; k <= NP; k++)
                    if (win < 0 && old[(m_cur + k) % NP] == S_PRONTO) win = (m_cur + k) % NP;
                if (win >= 0) begin
                    m_st[win] = S_EXEC; m_cur = win; m_prox = m_pc[win];
                    m_q = QN; m_troca = 1; m_fsm = F_RUN;
                end else begin
                    m_fsm = F_IDLE;
                end
            end
            default: begin
                q0 = m_q;
                m_q = q0 - 1;
                if (bus.fim_processo) begin
                    m_st[m_cur] = S_LIVRE; m_salvo = 0; m_fsm = F_SEL;
                end else if (bus.instr_io) begin
                    m_st[m_cur] = S_BLOQ; m_pc[m_cur] = bus.pc; m_salvo = bus.pc;
                    m_fsm = F_SEL; blocked = m_cur;
                end else if (q0 == 1) begin
                    m_st[m_cur] = S_PRONTO; m_pc[m_cur] = bus.pc; m_salvo = bus.pc;
                    m_fsm = F_SEL;
                end
            end
        endcase
        if (bus.io_done) begin
            p = int'(bus.io_done_pid);
            if (old[p] == S_BLOQ || p == blocked) m_st[p] = S_PRONTO;
        end
        if (bus.cria_valid) begin
            p = int'(bus.cria_pid);
            if (p < NP && old[p] == S_LIVRE) begin
                m_st[p] = S_PRONTO; m_pc[p] = bus.cria_pc;
            end else begin
                m_erro = 1;
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output shortly after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("troca",    32'(bus.troca_contexto), 32'(m_troca));
        chk("pc_prox",  bus.pc_proximo,          m_prox);
        chk("pc_salvo", bus.pc_salvo,            m_salvo);
        chk("atual",    32'(bus.processo_atual), 32'(m_cur));
        chk("quantum",  32'(bus.quantum_rest),   32'(m_q));
        chk("ocioso",   32'(bus.ocioso),         32'(m_fsm == F_IDLE));
        chk("erro",     32'(bus.erro_cria),      32'(m_erro));
    endtask

    task automatic clr_pulses();
        bus.instr_io = 0; bus.fim_processo = 0; bus.io_done = 0; bus.cria_valid = 0;
    endtask

    task automatic cria(input int pid, input logic [31:0] pc);
        bus.cria_valid = 1; bus.cria_pid = PW'(pid); bus.cria_pc = pc;
        tick();
        bus.cria_valid = 0;
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = 0;
        do begin tick(); n++; end while (!bus.troca_contexto && n < max);
        chk("pulse_seen", 32'(bus.troca_contexto), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_troca"},  32'(bus.troca_contexto), 32'd0);
        chk({tag, "_prox"},   bus.pc_proximo,          32'd0);
        chk({tag, "_salvo"},  bus.pc_salvo,            32'd0);
        chk({tag, "_atual"},  32'(bus.processo_atual), 32'd0);
        chk({tag, "_q"},      32'(bus.quantum_rest),   32'd0);
        chk({tag, "_ocioso"}, 32'(bus.ocioso),         32'd1);
        chk({tag, "_erro"},   32'(bus.erro_cria),      32'd0);
    endtask

    initial begin
        int n;
        bus.enable = 0; bus.pc = 0; bus.io_done_pid = 0; bus.cria_pid = 0; bus.cria_pc = 0;
        clr_pulses();

        // reset
        rst = 1;
        tick(); tick();
        chk_reset_vals("rst");
        rst = 0;
        bus.enable = 1;

        // two processes alternate with 4-cycle slices
        cria(1, 32'd100);
        cria(2, 32'd200);
        wait_pulse(10, n);
        chk("rr1_atual", 32'(bus.processo_atual), 32'd1);
        chk("rr1_prox",  bus.pc_proximo, 32'd100);
        bus.pc = 32'd111;
        wait_pulse(10, n);
        chk("rr2_gap",   32'(n), 32'd5);
        chk("rr2_atual", 32'(bus.processo_atual), 32'd2);
        chk("rr2_prox",  bus.pc_proximo, 32'd200);
        chk("rr2_salvo", bus.pc_salvo, 32'd111);
        bus.pc = 32'd222;
        wait_pulse(10, n);
        chk("rr3_gap",   32'(n), 32'd5);
        chk("rr3_atual", 32'(bus.processo_atual), 32'd1);
        chk("rr3_prox",  bus.pc_proximo, 32'd111);

        // IO block of pid1, then resume at its blocked PC
        bus.instr_io = 1; bus.pc = 32'd37;
        tick();
        clr_pulses();
        wait_pulse(10, n);
        chk("io_gap",   32'(n), 32'd1);
        chk("io_atual", 32'(bus.processo_atual), 32'd2);
        chk("io_salvo", bus.pc_salvo, 32'd37);
        bus.io_done = 1; bus.io_done_pid = 3'd1;
        tick();
        clr_pulses();
        wait_pulse(10, n);
        chk("resume_atual", 32'(bus.processo_atual), 32'd1);
        chk("resume_prox",  bus.pc_proximo, 32'd37);

        // IO and termination together: termination wins
        bus.instr_io = 1; bus.fim_processo = 1; bus.pc = 32'd55;
        tick();
        clr_pulses();
        chk("fimio_salvo", bus.pc_salvo, 32'd0);
        cria(2, 32'd999);
        chk("dup_erro", 32'(bus.erro_cria), 32'd1);
        tick();
        chk("dup_erro_off", 32'(bus.erro_cria), 32'd0);

        // last process ends -> idle; then a fresh create dispatches 2 edges later
        bus.fim_processo = 1;
        tick();
        clr_pulses();
        tick();
        chk("idle_ocioso", 32'(bus.ocioso), 32'd1);
        chk("idle_troca",  32'(bus.troca_contexto), 32'd0);
        tick();
        cria(5, 32'd9);
        chk("c5_e0", 32'(bus.troca_contexto), 32'd0);
        tick();
        chk("c5_e1", 32'(bus.troca_contexto), 32'd0);
        tick();
        chk("c5_pulse", 32'(bus.troca_contexto), 32'd1);
        chk("c5_prox",  bus.pc_proximo, 32'd9);
        chk("c5_atual", 32'(bus.processo_atual), 32'd5);

        // wrap-around from pid7 to pid0
        cria(7, 32'd70);
        bus.fim_processo = 1; tick(); clr_pulses();
        wait_pulse(10, n);
        chk("p7_atual", 32'(bus.processo_atual), 32'd7);
        cria(0, 32'd5);
        bus.fim_processo = 1; tick(); clr_pulses();
        wait_pulse(10, n);
        chk("wrap_atual", 32'(bus.processo_atual), 32'd0);
        chk("wrap_prox",  bus.pc_proximo, 32'd5);

        // reset mid-slice
        tick();
        rst = 1;
        tick();
        chk_reset_vals("midrst");
        rst = 0;
        tick();
        chk("post_rst_troca", 32'(bus.troca_contexto), 32'd0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bus.enable       = ($urandom_range(0, 9) != 0);
            bus.pc           = $urandom;
            bus.instr_io     = ($urandom_range(0, 11) == 0);
            bus.fim_processo = ($urandom_range(0, 19) == 0);
            bus.io_done      = ($urandom_range(0, 3) == 0);
            bus.io_done_pid  = PW'($urandom_range(0, NP - 1));
            bus.cria_valid   = ($urandom_range(0, 5) == 0);
            bus.cria_pid     = PW'($urandom_range(0, NP - 1));
            bus.cria_pc      = $urandom;
            rst              = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;
        clr_pulses();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
